// File: rtl/operand_pair_pkg.sv
// Shared types and default widths for the operand-pair transmit path.
package operand_pair_pkg;
  localparam int OP_DATA_W = 8;
  localparam int OP_SUM_W  = 16;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_e;

  typedef struct packed {
    logic [OP_DATA_W-1:0] a;
    logic [OP_DATA_W-1:0] b;
  } op_pair_t;
endpackage

// File: rtl/operand_pair_tx_if.sv
// Operand-pair bus: valid/ready input side plus the one-cycle output strobe.
interface operand_pair_tx_if
  import operand_pair_pkg::*;
#(
  parameter int DATA_W = OP_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic [DATA_W-1:0] a_o;
  logic [DATA_W-1:0] b_o;

  modport master (output in_valid, in_a, in_b, input in_ready, out_valid, a_o, b_o);
  modport slave  (input in_valid, in_a, in_b, output in_ready, out_valid, a_o, b_o);
endinterface

// File: rtl/op_pair_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to split full from empty.
module op_pair_fifo
  import operand_pair_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = op_pair_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head    = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/operand_pair_tx.sv
// Operand-pair transmitter: FIFO-buffered pairs sent as one-cycle strobes with a programmable gap.
// OPERAND_PAIR_TX_SUM_EN builds the running-sum accumulator; otherwise sum_o is tied to 0.
module operand_pair_tx
  import operand_pair_pkg::*;
#(
  parameter int DATA_W = OP_DATA_W,  // stored as op_pair_t, so must not exceed OP_DATA_W
  parameter int DEPTH  = 4,
  parameter int SUM_W  = OP_SUM_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_pair_tx_if.slave     bus,
  input  logic [3:0]           gap_cycles,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic [SUM_W-1:0]     sum_o,
  output logic                 busy
);
  tx_state_e  state;
  logic [3:0] gap_cnt;
  logic       full, empty, push, pop;
  op_pair_t   wdata, head;

  assign push         = bus.in_valid && !full;
  assign bus.in_ready = !full;
  assign busy         = !empty || (state != IDLE);
  assign wdata.a      = OP_DATA_W'(bus.in_a);
  assign wdata.b      = OP_DATA_W'(bus.in_b);

  op_pair_fifo #(.DEPTH(DEPTH), .T(op_pair_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Pop is exactly the set of edges that launch a new out_valid pulse.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      SEND:    pop = !empty && (gap_cycles == 4'd0);
      GAP:     pop = !empty && (gap_cnt == 4'd1);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      bus.out_valid <= 1'b0;
      bus.a_o       <= '0;
      bus.b_o       <= '0;
      sent_cnt      <= '0;
    end else begin
      bus.out_valid <= pop;
      if (pop) begin
        bus.a_o  <= DATA_W'(head.a);
        bus.b_o  <= DATA_W'(head.b);
        sent_cnt <= sent_cnt + 1'b1;
      end
      case (state)
        IDLE: if (!empty) state <= SEND;
        SEND: begin
          if (gap_cycles != 4'd0) begin
            state   <= GAP;
            gap_cnt <= gap_cycles;
          end else if (empty) begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd1) state <= empty ? IDLE : SEND;
          else                 gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OPERAND_PAIR_TX_SUM_EN
  logic [SUM_W-1:0] sum_r;

  always_ff @(posedge clk) begin
    if (rst)      sum_r <= '0;
    else if (pop) sum_r <= sum_r + SUM_W'(head.a) + SUM_W'(head.b);
  end

  assign sum_o = sum_r;
`else
  assign sum_o = '0;
`endif
endmodule

// File: tb/tb_operand_pair_tx.sv
// Directed bench for operand_pair_tx: latency, throughput, gap spacing, backpressure, wrap, reset.
module tb_operand_pair_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  gap_cycles;
  logic [15:0] sent_cnt;
  logic [15:0] sum_o;
  logic        busy;

  int errs = 0, checks = 0, cyc = 0;
  int last_push, stalls;
  int q_cyc[$], q_a[$], q_b[$];

  always #5 clk = ~clk;

  operand_pair_tx_if #(.DATA_W(8)) bus ();

  operand_pair_tx #(.DATA_W(8), .DEPTH(4), .SUM_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .gap_cycles (gap_cycles),
    .sent_cnt   (sent_cnt),
    .sum_o      (sum_o),
    .busy       (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is logged with the edge count that launched it.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      q_cyc.push_back(cyc);
      q_a.push_back(int'(bus.a_o));
      q_b.push_back(int'(bus.b_o));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xsum(input int v);
`ifdef OPERAND_PAIR_TX_SUM_EN
    return 32'(v) & 32'h0000_ffff;
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  function automatic int qv(input int idx, input int sel);
    if (idx >= q_cyc.size()) return -1;
    case (sel)
      0: return q_cyc[idx];
      1: return q_a[idx];
      default: return q_b[idx];
    endcase
  endfunction

  task automatic clear_log();
    q_cyc.delete(); q_a.delete(); q_b.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int a, input int b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a[7:0];
    bus.in_b = b[7:0];
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("push_timeout", 32'd1, 32'd0);
    stalls += n;
    @(negedge clk);
    last_push = cyc;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    gap_cycles = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    @(negedge clk);

    // reset state
    do_reset();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_a_o",       32'(bus.a_o),       32'd0);
    chk("rst_b_o",       32'(bus.b_o),       32'd0);
    chk("rst_sent_cnt",  32'(sent_cnt),      32'd0);
    chk("rst_sum_o",     32'(sum_o),         32'd0);
    chk("rst_busy",      32'(busy),          32'd0);

    // single pair, two-edge latency
    push(3, 4);
    repeat (4) @(negedge clk);
    chk("single_pulses",  32'(q_cyc.size()), 32'd1);
    chk("single_latency", 32'(qv(0, 0) - last_push), 32'd1);
    chk("single_a",       32'(qv(0, 1)), 32'd3);
    chk("single_b",       32'(qv(0, 2)), 32'd4);
    chk("single_a_hold",  32'(bus.a_o), 32'd3);
    chk("single_sent",    32'(sent_cnt), 32'd1);
    chk("single_sum",     32'(sum_o), xsum(7));
    chk("single_idle",    32'(busy), 32'd0);

    // back-to-back with gap 0
    do_reset();
    stalls = 0;
    for (int i = 1; i <= 4; i++) push(i, i);
    repeat (6) @(negedge clk);
    chk("b2b_pulses", 32'(q_cyc.size()), 32'd4);
    chk("b2b_span",   32'(qv(3, 0) - qv(0, 0)), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_a", 32'(qv(i, 1)), 32'(i + 1));
      chk("b2b_b", 32'(qv(i, 2)), 32'(i + 1));
    end
    chk("b2b_stalls", 32'(stalls), 32'd0);
    chk("b2b_sent",   32'(sent_cnt), 32'd4);
    chk("b2b_sum",    32'(sum_o), xsum(20));

    // gap 3 with backpressure
    do_reset();
    gap_cycles = 4'd3;
    stalls = 0;
    for (int i = 0; i < 6; i++) push(10 + i, 20 + i);
    repeat (30) @(negedge clk);
    chk("gap_pulses", 32'(q_cyc.size()), 32'd6);
    for (int i = 1; i < 6; i++) chk("gap_spacing", 32'(qv(i, 0) - qv(i - 1, 0)), 32'd4);
    for (int i = 0; i < 6; i++) begin
      chk("gap_a", 32'(qv(i, 1)), 32'(10 + i));
      chk("gap_b", 32'(qv(i, 2)), 32'(20 + i));
    end
    chk("gap_backpressure", 32'(stalls != 0), 32'd1);
    chk("gap_sent", 32'(sent_cnt), 32'd6);
    chk("gap_sum",  32'(sum_o), xsum(210));
    gap_cycles = 4'd0;

    // sum wrap: 258 * 510 = 131580 -> 0x01fc modulo 2^16
    do_reset();
    for (int i = 0; i < 258; i++) push(255, 255);
    repeat (5) @(negedge clk);
    chk("wrap_pulses", 32'(q_cyc.size()), 32'd258);
    chk("wrap_sent",   32'(sent_cnt), 32'd258);
    chk("wrap_sum",    32'(sum_o), xsum(258 * 510));

    // reset during GAP with pairs queued
    do_reset();
    gap_cycles = 4'd5;
    for (int i = 0; i < 4; i++) push(i + 1, i + 2);
    chk("midgap_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midgap_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midgap_busy_rst",  32'(busy), 32'd0);
    chk("midgap_sent",      32'(sent_cnt), 32'd0);
    chk("midgap_sum",       32'(sum_o), 32'd0);
    chk("midgap_in_ready",  32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    gap_cycles = 4'd0;
    clear_log();
    push(9, 1);
    repeat (8) @(negedge clk);
    chk("post_pulses", 32'(q_cyc.size()), 32'd1);
    chk("post_a",      32'(bus.a_o), 32'd9);
    chk("post_b",      32'(bus.b_o), 32'd1);
    chk("post_sent",   32'(sent_cnt), 32'd1);
    chk("post_sum",    32'(sum_o), xsum(10));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
